wb_bram_burst: RTL and testbench
================================

Name: wb_bram_burst

Overview:
- Parametrised Wishbone B4 block-RAM slave; successor to the fixed 32-bit single-port BRAM.
- Generalises data width and depth.
- Adds registered-feedback burst reads: incrementing linear, wrap-4, wrap-8 and wrap-16, one beat per clock after the first.
- Sits behind the interconnect as main on-chip memory for CPU and DMA masters.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8, power of two, 8..128.
- MEM_ADR_WIDTH, 11, log2 of word count (2048 words by default).
- ADR_WIDTH, 32, Wishbone byte-address width.
- Derived: SEL_W = DATA_WIDTH/8; LSB = log2(SEL_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cyc  in  1  bus cycle valid.
- stb  in  1  strobe.
- we  in  1  1 = write, 0 = read.
- adr  in  ADR_WIDTH  byte address.
- sel  in  SEL_W  byte-lane enables.
- dat_ms  in  DATA_WIDTH  write data.
- cti  in  3  cycle type identifier.
- bte  in  2  burst type extension.
- dat_sm  out  DATA_WIDTH  read data.
- ack  out  1  acknowledge.
- err  out  1  error.
- rty  out  1  retry; tied 0.

Behaviour:
- Request: req = cyc & stb. Word index idx = adr[MEM_ADR_WIDTH+LSB-1:LSB]. Memory contents are never reset.
- Reset (async, rst=1): state R_IDLE, dat_sm = 0, ack = 0, err = 0, internal beat index = 0. Takes effect immediately, including mid-burst. The burst is abandoned; no write occurs in a reset cycle.
- Writes (any state, req & we): ack = 1 combinationally in the same cycle (zero wait).
  - At the clock edge, mem[idx] lane i <= dat_ms[8i+:8] for each sel[i] = 1.
  - Write bursts therefore run one beat per cycle at the master-driven adr; cti and bte are ignored for writes.
- Read FSM, two states:
  - R_IDLE: ack from reads = 0. On req & !we: dat_sm <= mem[idx], beat <= idx, go to R_ACK.
  - R_ACK: ack = req & !we. Next state:
    - If req & !we & cti == 3'b010: stay in R_ACK; beat <= nxt(beat); dat_sm <= mem[nxt(beat)].
    - Otherwise (cti 000, 001, 111, reserved codes, stb or cyc dropped, we raised): go to R_IDLE; dat_sm holds its value.
- Read latency: first beat 1 wait state (ack in the cycle after stb). Subsequent incrementing beats have 0 wait states. Classic back-to-back reads get ack every other cycle. cti = 111 beat is acked, then ack drops.
- nxt(b), word-index arithmetic modulo 2^MEM_ADR_WIDTH:
  - bte 00 (linear): b+1; wraps from last word to word 0.
  - bte 01: low 2 bits increment mod 4, upper bits fixed.
  - bte 10: low 3 bits mod 8.
  - bte 11: low 4 bits mod 16.
  - If MEM_ADR_WIDTH is smaller than the wrap bit count, the wrap is on the full index.
- During a burst the slave uses its own predicted beat index, not adr. A master adr that disagrees with the prediction is a protocol violation; the slave returns mem[predicted].
- A write request arriving in R_ACK: write ack and memory update happen as for any write; FSM returns to R_IDLE.
- ack is never asserted without req. err = 0 unless the optional feature is enabled.

Optional Feature:
- Macro WB_BRAM_BURST_RANGE_ERR_EN.
- Enabled: adr bits [ADR_WIDTH-1:MEM_ADR_WIDTH+LSB] nonzero on a request give err = 1 instead of ack.
  - Write: combinational, same cycle; no memory update.
  - Read: err in the cycle after the request; FSM returns to R_IDLE; dat_sm unchanged.
  - Burst wrap-around inside memory is never an error.
- Disabled: upper address bits are ignored (memory aliases); err tied 0.

Test Plan:
- Reset: rst pulsed mid-burst at beat 3 -> ack = 0 and dat_sm = 0 immediately; next classic read of word 5 acks one cycle later with the stored value.
- Byte-lane write: write 0xDEADBEEF to adr 0x10 with sel = 1111, then 0x000000AA with sel = 0001 -> ack in the write cycle; classic read of 0x10 returns 0xDEADBEAA with ack one cycle after stb.
- Linear burst: preload words 0..7 with 0x100+i; read burst from adr 0x0, bte = 00, cti = 010 x7 then 111 -> acks on 8 consecutive cycles after a 1-cycle wait, data 0x100..0x107; ack low afterwards.
- Wrap-4 burst: read from word 6, bte = 01 -> data order words 6, 7, 4, 5; wrap-16 from the last word (2047, default params) -> 2047 then 2032.
- Read/write mix: classic read of word 1 immediately followed by a write to word 1 -> read data is the old value; write acked in its own cycle; the following read returns the new value.
- Range error (WB_BRAM_BURST_RANGE_ERR_EN defined): write to adr 0x0001_0000 (beyond default depth) -> err = 1, ack = 0, memory unchanged; without macro -> aliases to word 0, ack = 1.

Source files
------------

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with zero-wait writes and registered-feedback burst reads.
// Optional address range checking is enabled by defining WB_BRAM_BURST_RANGE_ERR_EN.
module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(SEL_W);
  localparam int DEPTH = 1 << MEM_ADR_WIDTH;

  typedef enum logic {R_IDLE, R_ACK} state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [MEM_ADR_WIDTH-1:0] idx;
  logic [MEM_ADR_WIDTH-1:0] beat;
  logic [MEM_ADR_WIDTH-1:0] beat_nxt;
  logic                     req;
  logic                     range_bad;
  logic                     rd_err;
  logic                     wr_en;
  logic                     burst_go;
  logic                     unused_bits;

  // Handshake: a transfer completes in any cycle where cyc & stb are high and the
  // slave answers with ack (or err); the master holds adr/we/sel/dat_ms until then.
  assign req = cyc & stb;
  assign idx = adr[MEM_ADR_WIDTH+LSB-1:LSB];

`ifdef WB_BRAM_BURST_RANGE_ERR_EN
  assign range_bad = |(adr >> (MEM_ADR_WIDTH + LSB));
`else
  assign range_bad = 1'b0;
`endif

  assign unused_bits = ^adr;

  // Wrap bursts increment only the low bits selected by bte; upper index bits stay fixed.
  function automatic logic [MEM_ADR_WIDTH-1:0] nxt(input logic [MEM_ADR_WIDTH-1:0] b,
                                                   input logic [1:0] t);
    logic [MEM_ADR_WIDTH-1:0] m;
    case (t)
      2'b01:   m = MEM_ADR_WIDTH'(4'h3);
      2'b10:   m = MEM_ADR_WIDTH'(4'h7);
      2'b11:   m = MEM_ADR_WIDTH'(4'hf);
      default: m = '1;
    endcase
    return (b & ~m) | ((b + 1'b1) & m);
  endfunction

  assign beat_nxt = nxt(beat, bte);
  assign burst_go = req & ~we & (cti == 3'b010);
  assign wr_en    = req & we & ~range_bad;
  assign rty      = 1'b0;

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    if (!rst && req) begin
      if (we) begin
        ack = ~range_bad;
        err = range_bad;
      end else if (state == R_ACK) begin
        ack = ~rd_err;
        err = rd_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel[i]) mem[idx][8*i +: 8] <= dat_ms[8*i +: 8];
      end
    end
  end

  // The beat after the current one is fetched while the current one is acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= R_IDLE;
      dat_sm <= '0;
      beat   <= '0;
      rd_err <= 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (req && !we) begin
            state  <= R_ACK;
            rd_err <= range_bad;
            if (!range_bad) begin
              dat_sm <= mem[idx];
              beat   <= idx;
            end
          end
        end
        R_ACK: begin
          if (burst_go && !rd_err) begin
            beat   <= beat_nxt;
            dat_sm <= mem[beat_nxt];
          end else begin
            state  <= R_IDLE;
            rd_err <= 1'b0;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Bench for wb_bram_burst: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level memory model.
module tb_wb_bram_burst;

  localparam int DW    = 32;
  localparam int MAW   = 11;
  localparam int AW    = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [3:0]    sel;
  logic [DW-1:0] dat_ms;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_sm;
  logic          ack, err, rty;

  wb_bram_burst #(.DATA_WIDTH(DW), .MEM_ADR_WIDTH(MAW), .ADR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        is_wr;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          n;
    logic [1:0]  bte;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic is_wr, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d, input int n,
                              input logic [1:0] bt, input logic [31:0] e);
    vec_t v;
    v.name = name; v.is_wr = is_wr; v.adr = a; v.sel = s; v.wdat = d;
    v.n = n; v.bte = bt; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                         input logic [3:0] se, input logic [31:0] d, input logic [2:0] ct,
                         input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; sel = se; dat_ms = d; cti = ct; bte = bt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Word visited on beat k of a burst: linear walks the whole memory, wrap-N stays in
  // the aligned N-word block containing the start word.
  function automatic int beat_idx(input int start, input int k, input logic [1:0] bt);
    int w;
    int base;
    case (bt)
      2'b00:   w = DEPTH;
      2'b01:   w = 4;
      2'b10:   w = 8;
      default: w = 16;
    endcase
    base = start - (start % w);
    return base + ((start - base + k) % w);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic exp_err);
    set_bus(1, 1, 1, a, s, d, 3'b000, 2'b00);
    @(negedge clk);
    check("wr_ack", ack, !exp_err);
    check("wr_err", err, exp_err);
    if (!exp_err)
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[a[12:2]][8*i +: 8] = d[8*i +: 8];
    next_cycle();
  endtask

  task automatic bus_read(input string name, input int start, input int n, input logic [1:0] bt,
                          input logic [2:0] last_cti, input logic bad_adr,
                          input logic [31:0] exp_first, input logic chk_first);
    logic [DW-1:0] e;
    logic [31:0]   a;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[beat_idx(start, k, bt)]);
    set_bus(1, 1, 0, 32'(start) << 2, 4'hf, $urandom, (n == 1) ? last_cti : 3'b010, bt);
    @(negedge clk);
    check({name, "_wait_ack"}, ack, 1'b0);
    check({name, "_wait_err"}, err, 1'b0);
    next_cycle();
    for (int k = 0; k < n; k++) begin
      cti = (k == n - 1) ? last_cti : 3'b010;
      a = 32'(beat_idx(start, k, bt)) << 2;
      if (bad_adr) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      adr = a;
      @(negedge clk);
      e = exp_q.pop_front();
      check({name, "_ack"}, ack, 1'b1);
      check({name, "_data"}, dat_sm, e);
      if (k == 0 && chk_first) check({name, "_const"}, dat_sm, exp_first);
      next_cycle();
    end
    set_bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
    @(negedge clk);
    check({name, "_end_ack"}, ack, 1'b0);
    check({name, "_rty"}, rty, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dat", dat_sm, '0);
    check("rst_rty", rty, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Preload the whole memory so every read has a known expected value.
    for (int i = 0; i < DEPTH; i++) bus_write(32'(i) << 2, 4'hf, $urandom, 1'b0);

    tbl.push_back(mk("wr_full",  1, 32'h10, 4'hf, 32'hDEADBEEF, 0, 2'b00, 0));
    tbl.push_back(mk("wr_lane0", 1, 32'h10, 4'h1, 32'h000000AA, 0, 2'b00, 0));
    tbl.push_back(mk("rd_lane",  0, 32'h10, 4'hf, 0, 1, 2'b00, 32'hDEADBEAA));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk("wr_pre", 1, 32'(i) << 2, 4'hf, 32'h100 + 32'(i), 0, 2'b00, 0));
    tbl.push_back(mk("rd_lin8",  0, 32'h00, 4'hf, 0, 8, 2'b00, 32'h100));
    tbl.push_back(mk("rd_wrap4", 0, 32'h18, 4'hf, 0, 4, 2'b01, 32'h106));
    tbl.push_back(mk("rd_wrap8", 0, 32'h14, 4'hf, 0, 8, 2'b10, 32'h105));
    tbl.push_back(mk("wr_top",   1, 32'h1FFC, 4'hf, 32'hCAFE07FF, 0, 2'b00, 0));
    tbl.push_back(mk("wr_2032",  1, 32'h1FC0, 4'hf, 32'hCAFE07F0, 0, 2'b00, 0));
    tbl.push_back(mk("rd_wrap16", 0, 32'h1FFC, 4'hf, 0, 2, 2'b11, 32'hCAFE07FF));
    tbl.push_back(mk("rd_lin_end", 0, 32'h1FF8, 4'hf, 0, 4, 2'b00, 32'hFFFFFFFF));
    tbl.push_back(mk("rd_old",   0, 32'h04, 4'hf, 0, 1, 2'b00, 32'h101));
    tbl.push_back(mk("wr_new",   1, 32'h04, 4'hf, 32'h11111111, 0, 2'b00, 0));
    tbl.push_back(mk("rd_new",   0, 32'h04, 4'hf, 0, 1, 2'b00, 32'h11111111));

    foreach (tbl[i]) begin
      if (tbl[i].is_wr)
        bus_write(tbl[i].adr, tbl[i].sel, tbl[i].wdat, 1'b0);
      else
        bus_read(tbl[i].name, int'(tbl[i].adr >> 2), tbl[i].n, tbl[i].bte,
                 (tbl[i].n == 1) ? 3'b000 : 3'b111, 1'b0, tbl[i].exp,
                 tbl[i].name != "rd_lin_end");
    end

    // Write arriving while a burst is in R_ACK; the next read must see a one-cycle wait.
    set_bus(1, 1, 0, 32'h0, 4'hf, '0, 3'b010, 2'b00);
    @(negedge clk);
    check("rack_wait", ack, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rack_beat0_ack", ack, 1'b1);
    check("rack_beat0_dat", dat_sm, ref_mem[0]);
    next_cycle();
    bus_write(32'd20 << 2, 4'hf, 32'h77770001, 1'b0);
    bus_read("rd_after_rack_wr", 20, 1, 2'b00, 3'b000, 1'b0, 32'h77770001, 1'b1);

`ifdef WB_BRAM_BURST_RANGE_ERR_EN
    bus_write(32'h0001_0000, 4'hf, 32'h5555AAAA, 1'b1);
    bus_read("rd_w0_kept", 0, 1, 2'b00, 3'b000, 1'b0, 32'h100, 1'b1);
    set_bus(1, 1, 0, 32'h0001_0000, 4'hf, '0, 3'b000, 2'b00);
    @(negedge clk);
    check("rderr_wait_err", err, 1'b0);
    check("rderr_wait_ack", ack, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rderr_err", err, 1'b1);
    check("rderr_ack", ack, 1'b0);
    check("rderr_dat", dat_sm, 32'h100);
    next_cycle();
    set_bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
    @(negedge clk);
    check("rderr_end", err, 1'b0);
    next_cycle();
    bus_read("rd_after_err", 3, 1, 2'b00, 3'b000, 1'b0, 32'h103, 1'b1);
`else
    bus_write(32'h0001_0000, 4'hf, 32'h5555AAAA, 1'b0);
    bus_read("rd_alias", 0, 1, 2'b00, 3'b000, 1'b0, 32'h5555AAAA, 1'b1);
`endif

    // Reset pulsed while the fourth beat of a linear burst is being presented.
    set_bus(1, 1, 0, 32'h0, 4'hf, '0, 3'b010, 2'b00);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      adr = 32'(k) << 2;
      @(negedge clk);
      check("rstb_ack", ack, 1'b1);
      check("rstb_dat", dat_sm, ref_mem[k]);
      next_cycle();
    end
    rst = 1'b1;
    set_bus(1, 1, 1, 32'd9 << 2, 4'hf, 32'hBAD0BAD0, 3'b010, 2'b00);
    #1;
    check("rstb_now_ack", ack, 1'b0);
    check("rstb_now_dat", dat_sm, '0);
    check("rstb_now_err", err, 1'b0);
    @(negedge clk);
    check("rstb_neg_ack", ack, 1'b0);
    next_cycle();
    rst = 1'b0;
    set_bus(0, 0, 0, '0, '0, '0, 3'b000, 2'b00);
    next_cycle();
    bus_read("rd_no_rst_wr", 9, 1, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0);
    bus_read("rd_w5", 5, 1, 2'b00, 3'b000, 1'b0, 32'h105, 1'b1);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus_write(32'($urandom_range(0, DEPTH - 1)) << 2, 4'($urandom_range(0, 15)),
                  $urandom, 1'b0);
      end else begin
        logic [2:0] lc;
        case ($urandom_range(0, 3))
          0:       lc = 3'b111;
          1:       lc = 3'b000;
          2:       lc = 3'b010;
          default: lc = 3'b001;
        endcase
        bus_read("rnd_rd", $urandom_range(0, DEPTH - 1), $urandom_range(1, 16),
                 2'($urandom_range(0, 3)), lc, $urandom_range(0, 3) == 0, 32'h0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
